// File: rtl/mult_8bit_seq.sv
// Sequential 8x8 unsigned shift-and-add multiplier: one iteration per clock, 8 iterations per product.
// Shares a single ripple-style adder_8bit between all iterations.

module adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c_in,
  output logic [7:0] sum,
  output logic       c_out
);
  logic [8:0] w_full;

  assign w_full = {1'b0, a} + {1'b0, b} + {8'b0, c_in};
  assign sum    = w_full[7:0];
  assign c_out  = w_full[8];
endmodule

module mult_8bit_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);
  // state | meaning
  // IDLE  | waiting for start, registers hold
  // BUSY  | eight shift-and-add iterations
  // DONE  | product valid, one-cycle done pulse
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_mcand;
  logic [7:0]  r_acc_hi;
  logic [7:0]  r_acc_lo;
  logic [2:0]  r_cnt;
  logic [15:0] r_product;

  logic [7:0]  w_add_b;
  logic [7:0]  w_sum;
  logic        w_cout;
  logic [7:0]  w_hi_nxt;
  logic [7:0]  w_lo_nxt;
  logic        w_last;

  assign w_add_b  = r_acc_lo[0] ? r_mcand : 8'h00;
  assign w_hi_nxt = {w_cout, w_sum[7:1]};
  assign w_lo_nxt = {w_sum[0], r_acc_lo[7:1]};
  assign w_last   = (r_cnt == 3'd7);

  adder_8bit u_adder (
    .a     (r_acc_hi),
    .b     (w_add_b),
    .c_in  (1'b0),
    .sum   (w_sum),
    .c_out (w_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: if (start) w_state_nxt = BUSY;
      BUSY: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand   <= 8'h00;
      r_acc_hi  <= 8'h00;
      r_acc_lo  <= 8'h00;
      r_cnt     <= 3'd0;
      r_product <= 16'h0000;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_mcand  <= a;
          r_acc_lo <= b;
          r_acc_hi <= 8'h00;
          r_cnt    <= 3'd0;
        end
        BUSY: begin
          r_acc_hi <= w_hi_nxt;
          r_acc_lo <= w_lo_nxt;
          // 7 -> 0 wrap lines up with leaving BUSY
          r_cnt    <= r_cnt + 3'd1;
          if (w_last) r_product <= {w_hi_nxt, w_lo_nxt};
        end
        default: ;
      endcase
    end
  end

  assign product = r_product;
endmodule

// File: tb/tb_mult_8bit_seq.sv
// Self-checking bench for mult_8bit_seq: scoreboard of expected products popped on each done pulse.

module tb_mult_8bit_seq;
  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  logic [15:0] sb_q[$];
  logic [15:0] last_prod;

  mult_8bit_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on done; product must not move during BUSY.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        n_done++;
        if (sb_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else                  chk("product", {16'h0, product}, {16'h0, sb_q.pop_front()});
      end
      if (busy && product !== last_prod) chk("prod_hold", {16'h0, product}, {16'h0, last_prod});
    end
    last_prod = product;
  end

  // One operation from IDLE; optionally re-pulses start with other operands during BUSY.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input bit repulse);
    int busy_cnt = 0;
    int lat = -1;
    @(negedge clk);
    start = 1'b1; a = ta; b = tb;
    @(posedge clk);
    sb_q.push_back(16'(ta) * 16'(tb));
    #1;
    start = 1'b0;
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin lat = i; break; end
      if (busy) busy_cnt++;
      if (repulse) begin
        start = (i >= 1 && i <= 5);
        a = 8'd9; b = 8'd9;
      end
    end
    start = 1'b0;
    chk("busy_cycles", busy_cnt, 32'd8);
    chk("latency", lat, 32'd8);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int d0;
    int dn[3];
    int nd;
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_product", {16'h0, product}, 32'd0);
    @(negedge clk); rst = 1'b0;

    run_op(8'd13, 8'd11, 1'b0);
    chk("prod_13x11", {16'h0, product}, 32'h008F);
    run_op(8'hFF, 8'hFF, 1'b0);
    chk("prod_ffxff", {16'h0, product}, 32'hFE01);
    run_op(8'h00, 8'hA5, 1'b0);
    chk("prod_0xa5", {16'h0, product}, 32'h0000);
    run_op(8'h80, 8'h02, 1'b0);
    chk("prod_80x02", {16'h0, product}, 32'h0100);

    d0 = n_done;
    run_op(8'd3, 8'd4, 1'b1);
    repeat (4) @(negedge clk);
    chk("repulse_prod", {16'h0, product}, 32'h000C);
    chk("repulse_one_done", n_done - d0, 32'd1);
    chk("repulse_idle", {31'd0, busy}, 32'd0);

    // Reset mid-operation at iteration 4
    @(negedge clk);
    start = 1'b1; a = 8'd7; b = 8'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_product", {16'h0, product}, 32'd0);
    @(negedge clk); rst = 1'b0;
    d0 = n_done;
    repeat (12) @(negedge clk);
    chk("abort_no_done", n_done - d0, 32'd0);
    chk("abort_product_held", {16'h0, product}, 32'd0);
    run_op(8'd2, 8'd5, 1'b0);
    chk("post_abort_prod", {16'h0, product}, 32'h000A);

    // start held high: one accept every 10 cycles
    @(negedge clk);
    start = 1'b1; a = 8'd6; b = 8'd7;
    repeat (3) sb_q.push_back(16'h002A);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        dn[nd] = i; nd++;
        if (nd == 3) begin start = 1'b0; break; end
      end
    end
    chk("hold_done_cnt", nd, 32'd3);
    if (nd == 3) begin
      chk("hold_spacing1", dn[1] - dn[0], 32'd10);
      chk("hold_spacing2", dn[2] - dn[1], 32'd10);
    end
    repeat (3) @(negedge clk);
    chk("hold_stopped", {31'd0, busy}, 32'd0);

    for (int k = 0; k < 10000; k++) begin
      @(negedge clk);
      start = 1'b1;
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      @(posedge clk);
      sb_q.push_back(16'(a) * 16'(b));
      #1 start = 1'b0;
      nd = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (done) begin nd = 1; break; end
      end
      if (nd == 0) chk("rand_timeout", 32'd0, 32'd1);
    end

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
